// File: rtl/axistream_unpack_pkg.sv
// Shared types and helpers for the axistream_unpack width-down converter.
package axistream_unpack_pkg;

  // The main slot is either idle or streaming its elements out
  typedef enum logic {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  // Ceiling log2, used to size the element index counter
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axistream_unpack_slot.sv
// Holding slot for one wide word: data, tlast flag and valid flag.
// A load takes priority over a clear so a slot can be retired and
// refilled in the same cycle.
module axistream_unpack_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] word_in,
  input  logic             tlast_in,
  output logic [WIDTH-1:0] word,
  output logic             tlast,
  output logic             valid
);

  // Capture a new word on load, drop the valid flag on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      tlast <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      word  <= word_in;
      tlast <= tlast_in;
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axistream_unpack.sv
// axistream_unpack: splits one wide AXI-stream word of NUM_PACK elements into
// NUM_PACK narrow beats, element 0 first. dest_tlast marks the final element
// of a word that arrived with src_tlast set.
// Optional macro AXISTREAM_UNPACK_PREFETCH_EN adds a spare slot so a following
// word can be accepted while the current one drains, removing the bubble
// cycle between words.
module axistream_unpack
  import axistream_unpack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         src_tvalid,
  output logic                         src_tready,
  input  logic [NUM_PACK*DATA_WIDTH-1:0] src_tdata,
  input  logic                         src_tlast,
  output logic                         dest_tvalid,
  input  logic                         dest_tready,
  output logic [DATA_WIDTH-1:0]        dest_tdata,
  output logic                         dest_tlast
);

  localparam int WORD_W = NUM_PACK * DATA_WIDTH;
  localparam int IDX_W  = clog2(NUM_PACK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PACK - 1);

  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  idx_next;
  logic [WORD_W-1:0] main_word;
  logic              main_tlast;
  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic [WORD_W-1:0] main_word_in;
  logic              main_tlast_in;
  state_t            state;
  logic              src_hs;
  logic              dest_hs;
  logic              retire;

  // The main slot's valid flag is the state register
  assign state   = main_valid ? SEND : EMPTY;
  assign src_hs  = src_tvalid && src_tready;
  assign dest_hs = dest_tvalid && dest_tready;
  assign retire  = dest_hs && (idx_reg == LAST_IDX);

  axistream_unpack_slot #(.WIDTH(WORD_W)) u_main_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clear    (main_clear),
    .word_in  (main_word_in),
    .tlast_in (main_tlast_in),
    .word     (main_word),
    .tlast    (main_tlast),
    .valid    (main_valid)
  );

`ifdef AXISTREAM_UNPACK_PREFETCH_EN
  logic              spare_load;
  logic              spare_clear;
  logic [WORD_W-1:0] spare_word;
  logic              spare_tlast;
  logic              spare_valid;

  axistream_unpack_slot #(.WIDTH(WORD_W)) u_spare_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (spare_load),
    .clear    (spare_clear),
    .word_in  (src_tdata),
    .tlast_in (src_tlast),
    .word     (spare_word),
    .tlast    (spare_tlast),
    .valid    (spare_valid)
  );

  // A full spare slot is the only thing that blocks the source
  assign src_tready = !spare_valid;
`else
  // Single slot: accept only when nothing is being streamed out
  assign src_tready = (state == EMPTY);
`endif

  // Next index and slot load/clear decisions
  always_comb begin
    idx_next      = idx_reg;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_word_in  = src_tdata;
    main_tlast_in = src_tlast;
`ifdef AXISTREAM_UNPACK_PREFETCH_EN
    spare_load    = 1'b0;
    spare_clear   = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (src_hs) begin
          main_load = 1'b1;
          idx_next  = '0;
        end
      end
      SEND: begin
        if (dest_hs) begin
          idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
        if (retire) begin
          main_clear = 1'b1;
        end
`ifdef AXISTREAM_UNPACK_PREFETCH_EN
        // Spare is only ever full while main is full, and it blocks the
        // source, so a retire with a full spare never coincides with src_hs
        if (retire && spare_valid) begin
          main_load     = 1'b1;
          main_word_in  = spare_word;
          main_tlast_in = spare_tlast;
          spare_clear   = 1'b1;
        end else if (src_hs) begin
          if (retire) begin
            main_load = 1'b1;
          end else begin
            spare_load = 1'b1;
          end
        end
`endif
      end
      default: begin
      end
    endcase
  end

  // Element index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else begin
      idx_reg <= idx_next;
    end
  end

  assign dest_tvalid = (state == SEND);
  assign dest_tdata  = DATA_WIDTH'(main_word >> (int'(idx_reg) * DATA_WIDTH));
  assign dest_tlast  = (state == SEND) && main_tlast && (idx_reg == LAST_IDX);

endmodule

// File: tb/tb_axistream_unpack.sv
// Scoreboard bench for axistream_unpack (DATA_WIDTH=8, NUM_PACK=4).
// Build with or without AXISTREAM_UNPACK_PREFETCH_EN.
module tb_axistream_unpack;

  localparam int DW = 8;
  localparam int NP = 4;
`ifdef AXISTREAM_UNPACK_PREFETCH_EN
  localparam int T3_SPAN = 7;
`else
  localparam int T3_SPAN = 8;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          src_tvalid = 1'b0;
  logic          src_tready;
  logic [31:0]   src_tdata = '0;
  logic          src_tlast = 1'b0;
  logic          dest_tvalid;
  logic          dest_tready = 1'b0;
  logic [DW-1:0] dest_tdata;
  logic          dest_tlast;

  always #5 clk = ~clk;

  axistream_unpack #(.DATA_WIDTH(DW), .NUM_PACK(NP)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_tvalid  (src_tvalid),
    .src_tready  (src_tready),
    .src_tdata   (src_tdata),
    .src_tlast   (src_tlast),
    .dest_tvalid (dest_tvalid),
    .dest_tready (dest_tready),
    .dest_tdata  (dest_tdata),
    .dest_tlast  (dest_tlast)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    hs_cyc_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rec_en = 1'b0;
  bit    rand_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks
  // that a stalled beat stays put
  initial begin
    beat_t         e;
    logic          stall_prev;
    logic [DW-1:0] data_prev;
    logic          last_prev;
    stall_prev = 1'b0;
    data_prev  = '0;
    last_prev  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 32'(dest_tvalid), 32'd1);
          check("hold_data", 32'(dest_tdata), 32'(data_prev));
          check("hold_last", 32'(dest_tlast), 32'(last_prev));
        end
        if (dest_tvalid && dest_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", dest_tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(dest_tdata), 32'(e.data));
            check("beat_last", 32'(dest_tlast), 32'(e.last));
            $display("beat data=0x%02h last=%0d", dest_tdata, dest_tlast);
          end
          if (rec_en) hs_cyc_q.push_back(cyc);
        end
        stall_prev = dest_tvalid && !dest_tready;
        data_prev  = dest_tdata;
        last_prev  = dest_tlast;
      end
    end
  end

  // Offer one wide word and queue its four expected beats when accepted
  task automatic send_word(input logic [31:0] w, input logic last);
    int waitc;
    bit done;
    waitc = 0;
    done = 1'b0;
    src_tvalid = 1'b1;
    src_tdata  = w;
    src_tlast  = last;
    while (!done) begin
      @(negedge clk);
      if (src_tready) begin
        for (int k = 0; k < NP; k++) begin
          exp_q.push_back('{w[k*DW +: DW], last && (k == NP - 1)});
        end
        $display("word 0x%08h tlast=%0d accepted", w, last);
        done = 1'b1;
      end else begin
        waitc++;
        if (waitc > 100) begin
          checks++;
          errors++;
          $display("FAIL src_accept_timeout: word 0x%08h not accepted, expected acceptance", w);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      if (rand_en) dest_tready = 1'($urandom_range(0, 1));
    end
    src_tvalid = 1'b0;
    src_tdata  = 32'hDEADBEEF;
    src_tlast  = 1'b1;
  endtask

  // Let all expected beats come out within a bounded number of cycles
  task automatic wait_drain();
    int n;
    n = 0;
    dest_tready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dest_tvalid", 32'(dest_tvalid), 32'd0);
    check("rst_dest_tlast", 32'(dest_tlast), 32'd0);
    check("rst_dest_tdata", 32'(dest_tdata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_src_tready", 32'(src_tready), 32'd1);
    check("rel_dest_tvalid", 32'(dest_tvalid), 32'd0);
    @(posedge clk);
    #1;

    // 1: single word, one-cycle latency to first beat
    dest_tready = 1'b1;
    send_word(32'h44332211, 1'b1);
    @(negedge clk);
    check("t1_latency_valid", 32'(dest_tvalid), 32'd1);
    check("t1_first_data", 32'(dest_tdata), 32'h11);
    wait_drain();

    // 2: stall for 5 cycles at element 2
    dest_tready = 1'b0;
    send_word(32'hDDCCBBAA, 1'b1);
    dest_tready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    dest_tready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t2_stall_valid", 32'(dest_tvalid), 32'd1);
      check("t2_stall_data", 32'(dest_tdata), 32'hCC);
      @(posedge clk);
      #1;
    end
    wait_drain();

    // 3: back-to-back words, throughput
    hs_cyc_q.delete();
    rec_en = 1'b1;
    dest_tready = 1'b1;
    send_word(32'h14131211, 1'b0);
    send_word(32'h18171615, 1'b1);
    wait_drain();
    rec_en = 1'b0;
    check("t3_beats", 32'(hs_cyc_q.size()), 32'd8);
    if (hs_cyc_q.size() >= 8) begin
      check("t3_span", 32'(hs_cyc_q[7] - hs_cyc_q[0]), 32'(T3_SPAN));
    end

    // 4: tlast only on the eighth beat across two words
    dest_tready = 1'b0;
    send_word(32'h24232221, 1'b0);
    dest_tready = 1'b1;
    send_word(32'h28272625, 1'b1);
    wait_drain();

    // 5: reset mid-word
    dest_tready = 1'b1;
    send_word(32'h44332211, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(dest_tvalid), 32'd0);
    check("t5_rst_last", 32'(dest_tlast), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_src_tready", 32'(src_tready), 32'd1);
    check("t5_no_partial", 32'(dest_tvalid), 32'd0);
    @(posedge clk);
    #1;
    send_word(32'h88776655, 1'b1);
    @(negedge clk);
    check("t5_first_data", 32'(dest_tdata), 32'h55);
    wait_drain();

    // 6: random source gaps and sink backpressure
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        dest_tready = 1'($urandom_range(0, 1));
      end
      send_word($urandom(), 1'($urandom_range(0, 1)));
    end
    rand_en = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
